// File: rtl/imem_program_loader.sv
// imem_program_loader: writer side of the instruction memory.
// Receives a framed byte stream (SYNC, LEN_HI, LEN_LO, 4*N data bytes, CSUM),
// packs big-endian 32-bit words and writes them to word addresses 0..N-1.
// The core is held (cpu_hold) from SYNC until a frame with a good checksum
// completes; a bad frame leaves it held with err set.
//
// Handshakes: a byte transfers on a posedge where in_valid && in_ready; a
// memory write transfers on a posedge where mem_we && mem_ready. Once raised,
// mem_we/mem_addr/mem_wdata stay unchanged until that transfer happens.
// DEPTH must not exceed 2**ADDR_W, and ADDR_W must be below 16 so that the
// word count slice of the 16-bit length is in range.
module imem_program_loader #(
    parameter int          ADDR_W = 8,
    parameter int          DEPTH  = 256,
    parameter logic [7:0]  SYNC   = 8'hA5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ready,
    output logic              cpu_hold,
    output logic              done,
    output logic              err,
    output logic [2:0]        dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEN_HI = 3'd1,
        S_LEN_LO = 3'd2,
        S_DATA   = 3'd3,
        S_WRITE  = 3'd4,
        S_CSUM   = 3'd5,
        S_DONE   = 3'd6,
        S_ERR    = 3'd7
    } state_e;

    localparam logic [16:0] DEPTH_L = 17'(DEPTH);

    state_e            state;
    logic [7:0]        len_hi;
    logic [ADDR_W:0]   n_words;
    logic [ADDR_W:0]   idx;
    logic [1:0]        byte_cnt;
    logic [23:0]       word_sr;
    logic [7:0]        csum;

    logic              accept;
    logic [15:0]       len_full;
    logic [ADDR_W:0]   idx_inc;

    assign accept    = in_valid && in_ready;
    assign len_full  = {len_hi, in_data};
    assign idx_inc   = idx + 1'b1;
    assign dbg_state = state;

    // Frame-parsing FSM; every output is registered here.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            in_ready  <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cpu_hold  <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            len_hi    <= '0;
            n_words   <= '0;
            idx       <= '0;
            byte_cnt  <= '0;
            word_sr   <= '0;
            csum      <= '0;
        end else begin
            case (state)
                // IDLE and ERR both discard bytes until SYNC starts a new frame.
                S_IDLE, S_ERR: begin
                    if (accept && in_data == SYNC) begin
                        state    <= S_LEN_HI;
                        cpu_hold <= 1'b1;
                        err      <= 1'b0;
                        csum     <= '0;
                        idx      <= '0;
                        byte_cnt <= '0;
                    end
                end
                S_LEN_HI: begin
                    if (accept) begin
                        len_hi <= in_data;
                        state  <= S_LEN_LO;
                    end
                end
                S_LEN_LO: begin
                    if (accept) begin
                        if ({1'b0, len_full} > DEPTH_L) begin
                            state <= S_ERR;
                            err   <= 1'b1;
                        end else begin
                            n_words <= len_full[ADDR_W:0];
                            state   <= (len_full == 16'd0) ? S_CSUM : S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (accept) begin
                        word_sr  <= {word_sr[15:0], in_data};
                        csum     <= csum ^ in_data;
                        byte_cnt <= byte_cnt + 2'd1;
                        // The fourth byte completes the word: issue the write.
                        if (byte_cnt == 2'd3) begin
                            mem_we    <= 1'b1;
                            mem_addr  <= idx[ADDR_W-1:0];
                            mem_wdata <= {word_sr, in_data};
                            in_ready  <= 1'b0;
                            state     <= S_WRITE;
                        end
                    end
                end
                S_WRITE: begin
                    if (mem_ready) begin
                        mem_we   <= 1'b0;
                        in_ready <= 1'b1;
                        idx      <= idx_inc;
                        state    <= (idx_inc == n_words) ? S_CSUM : S_DATA;
                    end
                end
                S_CSUM: begin
                    if (accept) begin
                        if (in_data == csum) begin
                            state    <= S_DONE;
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                            in_ready <= 1'b0;
                        end else begin
                            state <= S_ERR;
                            err   <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    done     <= 1'b0;
                    in_ready <= 1'b1;
                    state    <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_program_loader.sv
// Directed bench for imem_program_loader. Expected memory writes and done
// pulses are queued when a frame is issued; a negedge monitor pops and
// compares each one the DUT presents.
module tb_imem_program_loader;

    localparam int W = 41; // {is_done, addr[7:0], data[31:0]}

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic        cpu_hold;
    logic        done;
    logic        err;
    logic [2:0]  dbg_state;

    int vectors = 0;
    int miscompares = 0;
    logic [W-1:0] exp_q[$];

    localparam logic [7:0] FRAME1 [12] = '{8'hA5, 8'h00, 8'h02, 8'h80, 8'h01, 8'h06,
                                           8'h0A, 8'h04, 8'h01, 8'h10, 8'h00, 8'h98};

    imem_program_loader #(.ADDR_W(8), .DEPTH(256), .SYNC(8'hA5)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .cpu_hold  (cpu_hold),
        .done      (done),
        .err       (err),
        .dbg_state (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic push_write(input logic [7:0] addr, input logic [31:0] data);
        exp_q.push_back({1'b0, addr, data});
    endtask

    task automatic push_done();
        exp_q.push_back({1'b1, 8'h00, 32'h0});
    endtask

    // driver: present one byte and wait (bounded) for it to be accepted
    task automatic send_byte(input logic [7:0] b);
        int waited;
        bit accepted;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_data  = b;
        waited   = 0;
        accepted = 0;
        while (!accepted && waited < 100) begin
            @(negedge clk);
            if (in_ready) accepted = 1;
            @(posedge clk);
            #1;
            waited++;
        end
        in_valid = 1'b0;
        if (!accepted) begin
            vectors++;
            miscompares++;
            $display("FAIL send_byte_timeout: byte %h not accepted, expected acceptance", b);
        end
    endtask

    task automatic send_frame1(input logic [7:0] csum_byte);
        for (int i = 0; i < 11; i++) send_byte(FRAME1[i]);
        send_byte(csum_byte);
    endtask

    task automatic push_frame1_writes();
        push_write(8'd0, 32'h8001060A);
        push_write(8'd1, 32'h04011000);
    endtask

    // monitor / scoreboard
    task automatic sb_event(input logic [W-1:0] got, input string name);
        logic [W-1:0] exp;
        if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL %s_unexpected: got %h expected no event", name, got);
        end else begin
            exp = exp_q.pop_front();
            check(name, 64'(got), 64'(exp));
        end
    endtask

    always @(negedge clk) begin
        if (mem_we && mem_ready) sb_event({1'b0, mem_addr, mem_wdata}, "mem_write");
        if (done) sb_event({1'b1, 8'h00, 32'h0}, "done_pulse");
    end

    initial begin
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        mem_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_outputs",
              {in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, err},
              {1'b1, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 1'b0});
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Test 1: two-word load
        push_frame1_writes();
        push_done();
        send_byte(8'hA5);
        @(negedge clk);
        check("t1_hold_after_sync", cpu_hold, 1'b1);
        for (int i = 1; i < 12; i++) send_byte(FRAME1[i]);
        @(negedge clk);
        check("t1_done_pulse", done, 1'b1);
        check("t1_hold_released", {cpu_hold, err}, 2'b00);
        @(negedge clk);
        check("t1_done_one_cycle", done, 1'b0);
        check("t1_ready_idle", in_ready, 1'b1);

        // Test 2: bad checksum, then good frame
        push_frame1_writes();
        send_frame1(8'h99);
        @(negedge clk);
        check("t2_err_set", {err, cpu_hold}, 2'b11);
        repeat (2) @(negedge clk);
        check("t2_err_sticky", {err, cpu_hold, done}, 3'b110);
        push_frame1_writes();
        push_done();
        send_frame1(8'h98);
        @(negedge clk);
        check("t2_recover", {err, cpu_hold, done}, 3'b001);

        // Test 3: memory backpressure on word 0
        mem_ready = 1'b0;
        push_frame1_writes();
        push_done();
        for (int i = 0; i < 7; i++) send_byte(FRAME1[i]);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("t3_write_held", {mem_we, mem_addr, mem_wdata, in_ready},
                  {1'b1, 8'h00, 32'h8001060A, 1'b0});
        end
        @(posedge clk);
        #1;
        mem_ready = 1'b1;
        for (int i = 7; i < 12; i++) send_byte(FRAME1[i]);
        @(negedge clk);
        check("t3_done", {done, cpu_hold, err}, 3'b100);

        // Test 4: length overflow (N=257)
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h01);
        @(negedge clk);
        check("t4_overflow_err", {err, cpu_hold, in_ready, dbg_state}, {3'b111, 3'd7});
        repeat (4) @(negedge clk);
        check("t4_no_write", mem_we, 1'b0);

        // Test 5: garbage then empty frame
        push_done();
        send_byte(8'h12);
        send_byte(8'h34);
        @(negedge clk);
        check("t5_garbage_ignored", {err, cpu_hold}, 2'b11);
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h00);
        @(negedge clk);
        check("t5_empty_done", {done, cpu_hold, err}, 3'b100);

        // Test 6: async reset during data byte 6
        push_write(8'd0, 32'h8001060A);
        for (int i = 0; i < 8; i++) send_byte(FRAME1[i]);
        in_valid = 1'b1;
        in_data  = FRAME1[8];
        #2;
        rst = 1'b0;
        #1;
        check("t6_async_reset", {in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, err},
              {1'b1, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 1'b0});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst = 1'b1;
        check("t6_queue_drained_before_reload", 64'(exp_q.size()), 64'd0);
        push_frame1_writes();
        push_done();
        send_frame1(8'h98);
        @(negedge clk);
        check("t6_reload_done", {done, cpu_hold, err}, 3'b100);

        repeat (5) @(negedge clk);
        check("final_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
